// File: rtl/div_fix.sv
// Sequential restoring fixed-point divider: one quotient bit per cycle, valid/ready handshake.
// Optional round-to-nearest (ties away from zero) when DIV_FIX_ROUND_EN is defined.
module div_fix #(
  parameter int WIDTH  = 16,
  parameter int FBITS  = 0,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH + FBITS;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [WIDTH-1:0] ym_q, ym_d;
  logic             xneg_q, xneg_d;
  logic             sneg_q, sneg_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dbz_q, dbz_d, ovf_q, ovf_d;

  logic             x_neg, y_neg;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [N:0]       qm, lim_u, lim_p, lim_n;
  logic [WIDTH-1:0] rm;

  // |min| = 2^(WIDTH-1) still fits the unsigned magnitude width.
  assign x_neg = (SIGNED != 0) && x[WIDTH-1];
  assign y_neg = (SIGNED != 0) && y[WIDTH-1];
  assign x_mag = x_neg ? -x : x;
  assign y_mag = y_neg ? -y : y;

  // WIDTH+1-bit shift-subtract accumulator: remainder shifted left with the next dividend bit.
  assign trial = {acc_q, dvd_q[N-1]};
  assign ge    = trial >= {1'b0, ym_q};
  assign rm    = acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvd_d     = dvd_q;
    ym_d      = ym_q;
    xneg_d    = xneg_q;
    sneg_d    = sneg_q;
    q_d       = q_q;
    r_d       = r_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    qm        = {1'b0, dvd_q};
    lim_u     = '0;
    lim_p     = '0;
    lim_n     = '0;
    lim_u[WIDTH-1:0] = '1;
    lim_p[WIDTH-2:0] = '1;
    lim_n[WIDTH-1]   = 1'b1;
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StCalc) || (state_q == StFix);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          xneg_d = x_neg;
          sneg_d = x_neg ^ y_neg;
          ym_d   = y_mag;
          if (y == '0) begin
            q_d     = '0;
            r_d     = x;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = StDone;
          end else begin
            dvd_d   = N'(x_mag) << FBITS;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        acc_d = ge ? WIDTH'(trial - {1'b0, ym_q}) : trial[WIDTH-1:0];
        dvd_d = {dvd_q[N-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = StFix;
      end
      StFix: begin
`ifdef DIV_FIX_ROUND_EN
        if ({rm, 1'b0} >= {1'b0, ym_q}) qm = qm + {{N{1'b0}}, 1'b1};
`endif
        ovf_d = 1'b0;
        dbz_d = 1'b0;
        if (sneg_q) begin
          if (qm > lim_n) begin
            ovf_d = 1'b1;
            q_d   = lim_n[WIDTH-1:0];
          end else begin
            q_d   = -qm[WIDTH-1:0];
          end
        end else if (SIGNED != 0) begin
          if (qm > lim_p) begin
            ovf_d = 1'b1;
            q_d   = lim_p[WIDTH-1:0];
          end else begin
            q_d   = qm[WIDTH-1:0];
          end
        end else if (qm > lim_u) begin
          ovf_d = 1'b1;
          q_d   = '1;
        end else begin
          q_d   = qm[WIDTH-1:0];
        end
        // Remainder keeps the truncation value and takes the dividend's sign.
        r_d     = xneg_q ? -rm : rm;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      dvd_q   <= '0;
      ym_q    <= '0;
      xneg_q  <= 1'b0;
      sneg_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dvd_q   <= dvd_d;
      ym_q    <= ym_d;
      xneg_q  <= xneg_d;
      sneg_q  <= sneg_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = q_q;
  assign r   = r_q;
  assign dbz = dbz_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_div_fix.sv
// Directed bench for div_fix: three configurations (8/0/signed, 8/4/signed, 8/4/unsigned)
// driven with shared inputs; checks results, latency, stall, reset abort.
module tb_div_fix;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready;
  logic [7:0] x, y;

  logic       rdy_w[3], ov_w[3], dbz_w[3], ovf_w[3], busy_w[3];
  logic [7:0] q_w[3], r_w[3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_fix #(.WIDTH(8), .FBITS(0), .SIGNED(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[0]), .x(x), .y(y),
    .out_valid(ov_w[0]), .out_ready(out_ready), .q(q_w[0]), .r(r_w[0]), .dbz(dbz_w[0]),
    .ovf(ovf_w[0]), .busy(busy_w[0])
  );
  div_fix #(.WIDTH(8), .FBITS(4), .SIGNED(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[1]), .x(x), .y(y),
    .out_valid(ov_w[1]), .out_ready(out_ready), .q(q_w[1]), .r(r_w[1]), .dbz(dbz_w[1]),
    .ovf(ovf_w[1]), .busy(busy_w[1])
  );
  div_fix #(.WIDTH(8), .FBITS(4), .SIGNED(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w[2]), .x(x), .y(y),
    .out_valid(ov_w[2]), .out_ready(out_ready), .q(q_w[2]), .r(r_w[2]), .dbz(dbz_w[2]),
    .ovf(ovf_w[2]), .busy(busy_w[2])
  );

  // Per-vector expectations, packed as {C, B, A}.
  typedef struct packed {
    logic [7:0]      x;
    logic [7:0]      y;
    logic [2:0][7:0] q;
    logic [2:0][7:0] r;
    logic [2:0]      ovf;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] cq[3], cr[3];
  logic       cdbz[3], covf[3];
  int         lat[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] xv, input logic [7:0] yv);
    @(negedge clk);
    x = xv; y = yv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < 3; j++) lat[j] = -1;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (cyc == 1 && yv != 8'h00) begin
        check("busy_in_calc", {31'd0, busy_w[0]}, 32'd1);
        check("no_ready_in_calc", {31'd0, rdy_w[0]}, 32'd0);
      end
      for (int j = 0; j < 3; j++) begin
        if (ov_w[j] && lat[j] < 0) begin
          lat[j] = cyc; cq[j] = q_w[j]; cr[j] = r_w[j]; cdbz[j] = dbz_w[j]; covf[j] = ovf_w[j];
        end
      end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_vec(input int i);
    int exp_lat;
    run_op(vecs[i].x, vecs[i].y);
    for (int j = 0; j < 3; j++) begin
      exp_lat = (vecs[i].y == 8'h00) ? 0 : ((j == 0) ? 9 : 13);
      check($sformatf("v%0d_u%0d_lat", i, j), 32'(lat[j]), 32'(exp_lat));
      check($sformatf("v%0d_u%0d_q", i, j), {24'd0, cq[j]}, {24'd0, vecs[i].q[j]});
      check($sformatf("v%0d_u%0d_r", i, j), {24'd0, cr[j]}, {24'd0, vecs[i].r[j]});
      check($sformatf("v%0d_u%0d_dbz", i, j), {31'd0, cdbz[j]}, {31'd0, vecs[i].y == 8'h00});
      check($sformatf("v%0d_u%0d_ovf", i, j), {31'd0, covf[j]}, {31'd0, vecs[i].ovf[j]});
    end
  endtask

  initial begin
    int bad;
    vecs[0] = '{x: 8'hF9, y: 8'h02, q: {8'hFF, 8'hC8, 8'hFD}, r: {8'h00, 8'h00, 8'hFF},
                ovf: 3'b100};
    vecs[1] = '{x: 8'h64, y: 8'h00, q: {8'h00, 8'h00, 8'h00}, r: {8'h64, 8'h64, 8'h64},
                ovf: 3'b000};
    vecs[2] = '{x: 8'h80, y: 8'hFF, q: {8'h08, 8'h7F, 8'h7F}, r: {8'h08, 8'h00, 8'h00},
                ovf: 3'b011};
    vecs[3] = '{x: 8'h18, y: 8'h20, q: {8'h0C, 8'h0C, 8'h00}, r: {8'h00, 8'h00, 8'h18},
                ovf: 3'b000};
    vecs[4] = '{x: 8'hFF, y: 8'h10, q: {8'hFF, 8'hFF, 8'h00}, r: {8'h00, 8'h00, 8'hFF},
                ovf: 3'b000};
    vecs[5] = '{x: 8'h09, y: 8'h04, q: {8'h24, 8'h24, 8'h02}, r: {8'h00, 8'h00, 8'h01},
                ovf: 3'b000};
`ifdef DIV_FIX_ROUND_EN
    vecs[0].q[0] = 8'hFC;
    vecs[3].q[0] = 8'h01;
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_u%0d_ready", j), {31'd0, rdy_w[j]}, 32'd1);
      check($sformatf("rst_u%0d_busy", j), {31'd0, busy_w[j]}, 32'd0);
      check($sformatf("rst_u%0d_valid", j), {31'd0, ov_w[j]}, 32'd0);
      check($sformatf("rst_u%0d_qr", j), {16'd0, q_w[j], r_w[j]}, 32'd0);
    end

    for (int i = 0; i < 6; i++) do_vec(i);

    // Stall in DONE with out_ready low; an in_valid pulse meanwhile must be ignored.
    @(negedge clk);
    x = 8'h09; y = 8'h04; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bad = 1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (ov_w[0]) begin
        bad = 0;
        break;
      end
    end
    check("stall_reach_done", 32'(bad), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_hold", k), {14'd0, ov_w[0], rdy_w[0], q_w[0], r_w[0]},
            {14'd0, 1'b1, 1'b0, 8'h02, 8'h01});
      if (k == 1) begin
        x = 8'h55; y = 8'h03; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", {29'd0, rdy_w[0], rdy_w[1], ov_w[0]}, {29'd0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    check("pulse_ignored", {30'd0, ov_w[0], busy_w[0]}, 32'd0);

    // Reset after three CALC steps aborts the operation.
    @(negedge clk);
    x = 8'h55; y = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 2; j++) begin
      check($sformatf("abort_u%0d_ctl", j), {29'd0, rdy_w[j], busy_w[j], ov_w[j]},
            {29'd0, 1'b1, 1'b0, 1'b0});
      check($sformatf("abort_u%0d_out", j), {14'd0, dbz_w[j], ovf_w[j], q_w[j], r_w[j]}, 32'd0);
    end
    bad = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (ov_w[0] || ov_w[1] || ov_w[2]) bad++;
    end
    check("abort_no_valid", 32'(bad), 32'd0);
    do_vec(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
